// File: rtl/motor_encoders_pkg.sv
`default_nettype none
//============================================================================
// Module   : motor_pkg
// Purpose  : Quadrature states, speed limits and step helpers for motor_encoders.
// Revision : 1.0 - initial release
//============================================================================
package motor_pkg;

  // Encoded as {A,B}; forward order is Q00 -> Q10 -> Q11 -> Q01 -> Q00
  typedef enum logic [1:0] {
    Q00 = 2'b00,
    Q01 = 2'b01,
    Q10 = 2'b10,
    Q11 = 2'b11
  } quad_state_t;

  localparam int SPEED_MAX = 127;
  localparam int SPEED_MIN = -128;

  typedef logic signed [1:0] step_t;

  localparam step_t c_step_fwd  = 2'sb01;
  localparam step_t c_step_rev  = 2'sb11;
  localparam step_t c_step_none = 2'sb00;

  function automatic step_t quad_step(input quad_state_t from_s, input quad_state_t to_s);
    case ({from_s, to_s})
      {Q00, Q10}, {Q10, Q11}, {Q11, Q01}, {Q01, Q00}: return c_step_fwd;
      {Q00, Q01}, {Q01, Q11}, {Q11, Q10}, {Q10, Q00}: return c_step_rev;
      default:                                        return c_step_none;
    endcase
  endfunction

  function automatic logic is_illegal(input quad_state_t from_s, input quad_state_t to_s);
    return (from_s ^ to_s) == 2'b11;
  endfunction

  function automatic logic signed [7:0] saturate_speed(input int v);
    if (v > SPEED_MAX) return 8'sd127;
    if (v < SPEED_MIN) return -8'sd128;
    return 8'(v);
  endfunction

endpackage
`default_nettype wire

// File: rtl/motor_encoders_if.sv
`default_nettype none
//============================================================================
// Module   : motor_encoders_if
// Purpose  : Encoder pins, clear request and measurement outputs of motor_encoders.
// Revision : 1.0 - initial release
//============================================================================
interface motor_encoders_if #(
  parameter int POS_WIDTH = 32
) ();
  logic                        enc_left_a;
  logic                        enc_left_b;
  logic                        enc_right_a;
  logic                        enc_right_b;
  logic                        clear_in;
  logic signed [POS_WIDTH-1:0] position_left;
  logic signed [POS_WIDTH-1:0] position_right;
  logic signed [7:0]           speed_left;
  logic signed [7:0]           speed_right;
  logic                        speed_valid;
  logic                        error_left;
  logic                        error_right;

  modport master (
    output enc_left_a, enc_left_b, enc_right_a, enc_right_b, clear_in,
    input  position_left, position_right, speed_left, speed_right,
           speed_valid, error_left, error_right
  );

  modport slave (
    input  enc_left_a, enc_left_b, enc_right_a, enc_right_b, clear_in,
    output position_left, position_right, speed_left, speed_right,
           speed_valid, error_left, error_right
  );
endinterface
`default_nettype wire

// File: rtl/motor_encoders_quad_decoder.sv
`default_nettype none
//============================================================================
// Module   : quad_decoder
// Purpose  : One encoder channel: synchroniser, glitch filter, 4x decoder, position.
// Revision : 1.0 - initial release
//============================================================================
module quad_decoder
  import motor_pkg::*;
#(
  parameter int FILTER_CYCLES = 4,
  parameter int POS_WIDTH     = 32
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        i_enc_a,
  input  logic                        i_enc_b,
  input  logic                        i_clear,
  output step_t                       o_step,
  output logic signed [POS_WIDTH-1:0] o_position,
  output logic                        o_error
);

  localparam int                 c_cnt_w = $clog2(FILTER_CYCLES + 1);
  localparam logic [c_cnt_w-1:0] c_filt  = c_cnt_w'(FILTER_CYCLES);
  localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

  logic [1:0]                  r_a_sync;
  logic [1:0]                  r_b_sync;
  logic [1:0]                  r_fill;
  logic [1:0]                  r_cand;
  logic [c_cnt_w-1:0]          r_cnt;
  quad_state_t                 r_acc;
  logic                        r_acc_valid;
  quad_state_t                 r_state;
  quad_state_t                 w_state_next;
  logic                        r_base_valid;
  step_t                       w_step;
  logic                        w_illegal;
  logic [1:0]                  w_sample;
  logic [c_cnt_w-1:0]          w_cnt_next;
  logic signed [POS_WIDTH-1:0] r_pos;
  logic                        r_err;

  assign w_sample   = {r_a_sync[1], r_b_sync[1]};
  assign w_cnt_next = (w_sample != r_cand) ? c_one :
                      (r_cnt == c_filt)    ? r_cnt : r_cnt + 1'b1;

  // r_fill holds the filter off until the synchroniser carries real pin samples
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_a_sync    <= '0;
      r_b_sync    <= '0;
      r_fill      <= '0;
      r_cand      <= '0;
      r_cnt       <= '0;
      r_acc       <= Q00;
      r_acc_valid <= 1'b0;
    end else begin
      r_a_sync <= {r_a_sync[0], i_enc_a};
      r_b_sync <= {r_b_sync[0], i_enc_b};
      r_fill   <= {r_fill[0], 1'b1};
      if (r_fill[1]) begin
        r_cand <= w_sample;
        r_cnt  <= w_cnt_next;
        if (w_cnt_next == c_filt) begin
          r_acc       <= quad_state_t'(w_sample);
          r_acc_valid <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_state      <= Q00;
      r_base_valid <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (r_acc_valid) r_base_valid <= 1'b1;
    end
  end

  // The first accepted state only seeds r_state
  always_comb begin
    w_state_next = r_state;
    w_step       = c_step_none;
    w_illegal    = 1'b0;
    if (r_acc_valid) begin
      w_state_next = r_acc;
      if (r_base_valid) begin
        w_step    = quad_step(r_state, r_acc);
        w_illegal = is_illegal(r_state, r_acc);
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in || i_clear) begin
      r_pos <= '0;
      r_err <= 1'b0;
    end else begin
      r_pos <= r_pos + {{(POS_WIDTH-2){w_step[1]}}, w_step};
      if (w_illegal) r_err <= 1'b1;
    end
  end

  assign o_step     = w_step;
  assign o_position = r_pos;
  assign o_error    = r_err;

endmodule
`default_nettype wire

// File: rtl/motor_encoders.sv
`default_nettype none
//============================================================================
// Module   : motor_encoders
// Purpose  : Dual quadrature decoder with positions and windowed signed 8-bit speed.
// Revision : 1.0 - initial release
//============================================================================
module motor_encoders
  import motor_pkg::*;
#(
  parameter int SAMPLE_CYCLES = 98304,
  parameter int FILTER_CYCLES = 4,
  parameter int POS_WIDTH     = 32
) (
  input  logic             clk_in,
  input  logic             rst_in,
  motor_encoders_if.slave  bus
);

  localparam int                 c_win_w    = $clog2(SAMPLE_CYCLES);
  localparam int                 c_delta_w  = $clog2(SAMPLE_CYCLES + 1) + 1;
  localparam logic [c_win_w-1:0] c_win_last = c_win_w'(SAMPLE_CYCLES - 1);

  step_t                       w_step_l;
  step_t                       w_step_r;
  logic [c_win_w-1:0]          r_win;
  logic                        w_tc;
  logic signed [c_delta_w-1:0] r_delta_l;
  logic signed [c_delta_w-1:0] r_delta_r;
  logic signed [7:0]           r_speed_l;
  logic signed [7:0]           r_speed_r;
  logic                        r_valid;

  function automatic logic signed [c_delta_w-1:0] ext_step(input step_t s);
    return {{(c_delta_w-2){s[1]}}, s};
  endfunction

  quad_decoder #(
    .FILTER_CYCLES (FILTER_CYCLES),
    .POS_WIDTH     (POS_WIDTH)
  ) u_left (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .i_enc_a    (bus.enc_left_a),
    .i_enc_b    (bus.enc_left_b),
    .i_clear    (bus.clear_in),
    .o_step     (w_step_l),
    .o_position (bus.position_left),
    .o_error    (bus.error_left)
  );

  quad_decoder #(
    .FILTER_CYCLES (FILTER_CYCLES),
    .POS_WIDTH     (POS_WIDTH)
  ) u_right (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .i_enc_a    (bus.enc_right_a),
    .i_enc_b    (bus.enc_right_b),
    .i_clear    (bus.clear_in),
    .o_step     (w_step_r),
    .o_position (bus.position_right),
    .o_error    (bus.error_right)
  );

  assign w_tc = (r_win == c_win_last);

  // A step on the terminal-count cycle opens the next window's delta
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_win     <= '0;
      r_delta_l <= '0;
      r_delta_r <= '0;
      r_speed_l <= '0;
      r_speed_r <= '0;
      r_valid   <= 1'b0;
    end else begin
      r_valid <= w_tc;
      if (w_tc) begin
        r_win     <= '0;
        r_speed_l <= saturate_speed(int'(r_delta_l));
        r_speed_r <= saturate_speed(int'(r_delta_r));
        r_delta_l <= ext_step(w_step_l);
        r_delta_r <= ext_step(w_step_r);
      end else begin
        r_win     <= r_win + 1'b1;
        r_delta_l <= r_delta_l + ext_step(w_step_l);
        r_delta_r <= r_delta_r + ext_step(w_step_r);
      end
    end
  end

  assign bus.speed_left  = r_speed_l;
  assign bus.speed_right = r_speed_r;
  assign bus.speed_valid = r_valid;

endmodule
`default_nettype wire
